floo_vc_credit_return_buffer: RTL and testbench



---
 rtl/floo_vc_pkg.sv | 21 ++
 rtl/floo_vc_credit_fifo.sv | 70 +++++++
 rtl/floo_vc_credit_return_buffer.sv | 110 +++++++++++
 tb/tb_floo_vc_credit_return_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_vc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : floo_vc_pkg
//  Description : Shared types and defaults for the per-VC credit link
//                (receiver buffer and upstream credit counter).
//  Revision    : 1.0 - initial release
// ============================================================================
package floo_vc_pkg;

    localparam int unsigned c_DEFAULT_NUM_VC_WIDTH_MAX = 2;
    localparam int unsigned c_DEFAULT_VC_DEPTH         = 2;

    typedef logic [c_DEFAULT_NUM_VC_WIDTH_MAX-1:0] vc_id_t;

    typedef struct packed {
        logic   valid;
        vc_id_t id;
    } credit_t;

endpackage
`default_nettype wire

// File: rtl/floo_vc_credit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : floo_vc_credit_fifo
//  Description : Single-VC synchronous-reset FIFO; pointers wrap modulo Depth,
//                so Depth need not be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module floo_vc_credit_fifo #(
    parameter int unsigned Depth    = 2,
    parameter int unsigned Width    = 64,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [CntWidth-1:0] count_o
);

    localparam int unsigned         c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [c_PTR_W-1:0]  c_LAST  = c_PTR_W'(Depth - 1);

    logic [Width-1:0]    r_mem [Depth];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [CntWidth-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    // Guard locally so a misbehaving caller can never corrupt the count.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CntWidth'(Depth));
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/floo_vc_credit_return_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : floo_vc_credit_return_buffer
//  Description : Receiver end of the per-VC credit link: per-VC flit FIFOs,
//                one registered credit per pop, sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module floo_vc_credit_return_buffer
    import floo_vc_pkg::*;
#(
    parameter int unsigned NumVC         = 4,
    parameter int unsigned NumVCWidth    = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned NumVCWidthMax = c_DEFAULT_NUM_VC_WIDTH_MAX,
    parameter int unsigned VCDepth       = c_DEFAULT_VC_DEPTH,
    parameter int unsigned VCDepthWidth  = $clog2(VCDepth + 1),
    parameter int unsigned FlitWidth     = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flit_v_i,
    input  logic [NumVCWidthMax-1:0]            flit_id_i,
    input  logic [FlitWidth-1:0]                flit_data_i,
    output logic [NumVC-1:0]                    head_v_o,
    output logic [NumVC-1:0][FlitWidth-1:0]     head_data_o,
    input  logic                                pop_v_i,
    input  logic [NumVCWidthMax-1:0]            pop_id_i,
    output logic                                credit_v_o,
    output logic [NumVCWidthMax-1:0]            credit_id_o,
    output logic [NumVC-1:0][VCDepthWidth-1:0]  occupancy_o,
    output logic                                overflow_o
);

    // One extra bit so the range check works even when NumVC == 2**NumVCWidthMax.
    localparam logic [NumVCWidthMax:0] c_NUM_VC = (NumVCWidthMax + 1)'(NumVC);

    logic                     w_wr_ok;
    logic                     w_pop_ok;
    logic [NumVCWidth-1:0]    w_wr_idx;
    logic [NumVCWidth-1:0]    w_pop_idx;
    logic [NumVC-1:0]         w_wr_sel;
    logic [NumVC-1:0]         w_pop_sel;
    logic [NumVC-1:0]         w_push;
    logic [NumVC-1:0]         w_pop;
    logic [NumVC-1:0]         w_full;
    logic [NumVC-1:0]         w_empty;
    logic                     w_violation;

    logic                     r_credit_v;
    logic [NumVCWidthMax-1:0] r_credit_id;
    logic                     r_overflow;

    assign w_wr_ok   = ({1'b0, flit_id_i} < c_NUM_VC);
    assign w_pop_ok  = ({1'b0, pop_id_i} < c_NUM_VC);
    assign w_wr_idx  = flit_id_i[NumVCWidth-1:0];
    assign w_pop_idx = pop_id_i[NumVCWidth-1:0];

    for (genvar v = 0; v < NumVC; v++) begin : g_vc
        assign w_wr_sel[v]  = flit_v_i & w_wr_ok & (w_wr_idx == NumVCWidth'(v));
        assign w_pop_sel[v] = pop_v_i & w_pop_ok & (w_pop_idx == NumVCWidth'(v));
        // Full is judged before the same-cycle pop: upstream has not seen that credit yet.
        assign w_push[v]    = w_wr_sel[v] & ~w_full[v];
        assign w_pop[v]     = w_pop_sel[v] & ~w_empty[v];
        assign head_v_o[v]  = ~w_empty[v];

        floo_vc_credit_fifo #(
            .Depth    (VCDepth),
            .Width    (FlitWidth),
            .CntWidth (VCDepthWidth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (w_push[v]),
            .data_i  (flit_data_i),
            .pop_i   (w_pop[v]),
            .data_o  (head_data_o[v]),
            .empty_o (w_empty[v]),
            .full_o  (w_full[v]),
            .count_o (occupancy_o[v])
        );
    end

    assign w_violation = flit_v_i & (~w_wr_ok | (|(w_wr_sel & w_full)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit_v  <= 1'b0;
            r_credit_id <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_credit_v  <= |w_pop;
            r_credit_id <= (|w_pop) ? pop_id_i : '0;
            if (w_violation) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!w_violation)
                else $warning("floo_vc_credit_return_buffer: flit to full or invalid VC dropped");
        end
    end

    assign credit_v_o  = r_credit_v;
    assign credit_id_o = r_credit_id;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_floo_vc_credit_return_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floo_vc_credit_return_buffer
//  Description : Directed and credit-respecting random bench for the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_vc_credit_return_buffer;

    localparam int NV  = 4;
    localparam int DEP = 2;
    localparam int IDW = 3;
    localparam int DW  = $clog2(DEP + 1);
    localparam int FW  = 64;

    logic                       clk = 1'b0;
    logic                       rst_i;
    logic                       flit_v_i;
    logic [IDW-1:0]             flit_id_i;
    logic [FW-1:0]              flit_data_i;
    logic [NV-1:0]              head_v_o;
    logic [NV-1:0][FW-1:0]      head_data_o;
    logic                       pop_v_i;
    logic [IDW-1:0]             pop_id_i;
    logic                       credit_v_o;
    logic [IDW-1:0]             credit_id_o;
    logic [NV-1:0][DW-1:0]      occupancy_o;
    logic                       overflow_o;

    int n_cmp  = 0;
    int n_fail = 0;

    floo_vc_credit_return_buffer #(
        .NumVC         (NV),
        .NumVCWidthMax (IDW),
        .VCDepth       (DEP),
        .FlitWidth     (FW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flit_v_i    (flit_v_i),
        .flit_id_i   (flit_id_i),
        .flit_data_i (flit_data_i),
        .head_v_o    (head_v_o),
        .head_data_o (head_data_o),
        .pop_v_i     (pop_v_i),
        .pop_id_i    (pop_id_i),
        .credit_v_o  (credit_v_o),
        .credit_id_o (credit_id_o),
        .occupancy_o (occupancy_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input int fid, input logic [63:0] fd,
                         input logic pv, input int pid);
        flit_v_i    = fv;
        flit_id_i   = IDW'(fid);
        flit_data_i = fd;
        pop_v_i     = pv;
        pop_id_i    = IDW'(pid);
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Reference upstream credit counters and a per-VC data model.
    int          cnt [NV];
    logic [63:0] mq  [NV][DEP];
    int          mh  [NV];
    int          mn  [NV];

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 0, 64'h0, 1'b0, 0);

        // ---- 1: reset and two writes to VC2
        do_reset();
        check_value("rst_occ",      occupancy_o, '0);
        check_value("rst_head_v",   head_v_o, 4'b0000);
        check_value("rst_credit_v", credit_v_o, 1'b0);
        check_value("rst_credit_id", credit_id_o, 3'd0);
        check_value("rst_overflow", overflow_o, 1'b0);
        drive(1'b1, 2, 64'hA0, 1'b0, 0);
        tick();
        check_value("t1_head_v_c1", head_v_o, 4'b0100);
        drive(1'b1, 2, 64'hA1, 1'b0, 0);
        tick();
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        check_value("t1_head_v",   head_v_o, 4'b0100);
        check_value("t1_occ2",     occupancy_o[2], 2);
        check_value("t1_credit_v", credit_v_o, 1'b0);

        // ---- 2: pop VC2 twice
        tick();
        check_value("t2_head0", head_data_o[2], 64'hA0);
        drive(1'b0, 0, 64'h0, 1'b1, 2);
        tick();
        check_value("t2_credit_v1",  credit_v_o, 1'b1);
        check_value("t2_credit_id1", credit_id_o, 3'd2);
        check_value("t2_head1",      head_data_o[2], 64'hA1);
        tick();
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        check_value("t2_credit_v2",  credit_v_o, 1'b1);
        check_value("t2_credit_id2", credit_id_o, 3'd2);
        check_value("t2_occ2",       occupancy_o[2], 0);
        check_value("t2_head_v",     head_v_o, 4'b0000);
        tick();
        check_value("t2_credit_v3",  credit_v_o, 1'b0);

        // ---- 3: write+pop on full VC1
        drive(1'b1, 1, 64'hC0, 1'b0, 0);
        tick();
        drive(1'b1, 1, 64'hC1, 1'b0, 0);
        tick();
        check_value("t3_occ1_full", occupancy_o[1], 2);
        check_value("t3_ovf_pre",   overflow_o, 1'b0);
        drive(1'b1, 1, 64'hC2, 1'b1, 1);
        tick();
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        check_value("t3_overflow", overflow_o, 1'b1);
        check_value("t3_occ1",     occupancy_o[1], 1);
        check_value("t3_credit_v", credit_v_o, 1'b1);
        check_value("t3_credit_id", credit_id_o, 3'd1);
        check_value("t3_head1",    head_data_o[1], 64'hC1);
        tick();
        check_value("t3_credit_once", credit_v_o, 1'b0);
        check_value("t3_sticky",      overflow_o, 1'b1);

        // ---- 4: write+pop on VC0 holding one flit
        drive(1'b1, 0, 64'hB0, 1'b0, 0);
        tick();
        drive(1'b1, 0, 64'hB1, 1'b1, 0);
        tick();
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        check_value("t4_occ0",      occupancy_o[0], 1);
        check_value("t4_head0",     head_data_o[0], 64'hB1);
        check_value("t4_credit_v",  credit_v_o, 1'b1);
        check_value("t4_credit_id", credit_id_o, 3'd0);

        // ---- 5: empty pop, out-of-range ids
        do_reset();
        check_value("t5_ovf_rst", overflow_o, 1'b0);
        check_value("t5_occ_rst", occupancy_o, '0);
        drive(1'b0, 0, 64'h0, 1'b1, 3);
        tick();
        check_value("t5_empty_pop_credit", credit_v_o, 1'b0);
        check_value("t5_empty_pop_ovf",    overflow_o, 1'b0);
        drive(1'b1, 5, 64'hDEAD, 1'b0, 0);
        tick();
        check_value("t5_id5_ovf",    overflow_o, 1'b1);
        check_value("t5_id5_head_v", head_v_o, 4'b0000);
        check_value("t5_id5_occ",    occupancy_o, '0);
        drive(1'b1, 2, 64'hD0, 1'b0, 0);
        tick();
        drive(1'b0, 0, 64'h0, 1'b1, 6);
        tick();
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        check_value("t5_id6_pop_credit", credit_v_o, 1'b0);
        check_value("t5_id6_pop_occ2",   occupancy_o[2], 1);

        // ---- 6: credit-respecting random traffic with a mid-burst reset
        do_reset();
        for (int v = 0; v < NV; v++) begin
            cnt[v] = DEP;
            mh[v]  = 0;
            mn[v]  = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int          pid;
            int          wid;
            logic        pv;
            logic        wv;
            logic [63:0] wd;

            if (rst_i) begin
                rst_i = 1'b0;
                check_value("r_rst_occ",      occupancy_o, '0);
                check_value("r_rst_head_v",   head_v_o, 4'b0000);
                check_value("r_rst_credit_v", credit_v_o, 1'b0);
                check_value("r_rst_credit_id", credit_id_o, 3'd0);
                check_value("r_rst_overflow", overflow_o, 1'b0);
                for (int v = 0; v < NV; v++) begin
                    cnt[v] = DEP;
                    mh[v]  = 0;
                    mn[v]  = 0;
                end
            end

            for (int v = 0; v < NV; v++) begin
                int infl;
                infl = (credit_v_o && int'(credit_id_o) == v) ? 1 : 0;
                check_value("r_invariant", 64'(int'(occupancy_o[v]) + cnt[v] + infl), 64'(DEP));
                check_value("r_head_v", head_v_o[v], mn[v] != 0);
            end
            if (credit_v_o) begin
                cnt[int'(credit_id_o)]++;
            end

            if (cyc == 5000) begin
                rst_i = 1'b1;
                drive(1'b0, 0, 64'h0, 1'b0, 0);
            end else begin
                pv  = ($urandom_range(0, 1) == 1);
                pid = $urandom_range(0, NV - 1);
                wv  = ($urandom_range(0, 3) != 0);
                wid = $urandom_range(0, NV - 1);
                wd  = {$urandom, $urandom};
                if (pv && head_v_o[pid]) begin
                    check_value("r_head_data", head_data_o[pid], mq[pid][mh[pid]]);
                    mh[pid] = (mh[pid] + 1) % DEP;
                    mn[pid]--;
                end
                if (wv && cnt[wid] > 0) begin
                    cnt[wid]--;
                    mq[wid][(mh[wid] + mn[wid]) % DEP] = wd;
                    mn[wid]++;
                end else begin
                    wv = 1'b0;
                end
                drive(wv, wid, wd, pv, pid);
            end
            tick();
        end
        drive(1'b0, 0, 64'h0, 1'b0, 0);
        tick();
        check_value("r_end_overflow", overflow_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
